// File: rtl/fuzz_seq_pkg.sv
// Shared types and helpers for the fuzz wrapper sequencer: FSM state encoding,
// the Galois LFSR/MISR step shared by stimulus and compaction, and the response folder.
package fuzz_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    APPLY,
    WAIT,
    CAPTURE,
    DONE
  } seq_state_e;

  localparam logic [31:0] LFSR_TAPS  = 32'hA300_0000;
  // Widest out_flat the folder accepts; callers zero-pad into this width.
  localparam int unsigned FOLD_MAX_W = 1024;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // XOR of the 32-bit chunks that overlap the first 'width' bits; width 0 yields 0.
  function automatic logic [31:0] fold32(input logic [FOLD_MAX_W-1:0] v,
                                         input int unsigned width);
    logic [31:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < FOLD_MAX_W / 32; i++) begin
      if (i * 32 < width) acc ^= v[i*32 +: 32];
    end
    return acc;
  endfunction

endpackage

// File: rtl/fuzz_wrapper_sequencer_lfsr.sv
// fuzz_lfsr32: loadable, enable-gated 32-bit Galois LFSR; a zero seed loads as 1
// so the register can never lock up in the all-zero state.
module fuzz_lfsr32
  import fuzz_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [31:0] seed_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? 32'h1 : seed_i;
    end else if (en_i) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= 32'h1;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/fuzz_wrapper_sequencer.sv
// Seeded stimulus sequencer and MISR response compactor for flattened fuzz wrappers.
// Optional FUZZ_SEQ_ABORT_EN adds abort_i to cut a run short with a partial signature.
module fuzz_wrapper_sequencer
  import fuzz_seq_pkg::*;
#(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned STIM_W = (IN_W == 0) ? 1 : IN_W,
  localparam int unsigned RESP_W = (OUT_W == 0) ? 1 : OUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef FUZZ_SEQ_ABORT_EN
  input  logic              abort_i,
`endif
  input  logic              start_i,
  input  logic [31:0]       seed_i,
  input  logic [CNT_W-1:0]  num_vec_i,
  output logic [STIM_W-1:0] stim_o,
  input  logic [RESP_W-1:0] resp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  vec_cnt_o,
  output logic [31:0]       signature_o
);

  localparam logic [7:0] SETTLE_LAST = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);

  seq_state_e          state_q, state_d;
  logic [STIM_W-1:0]   stim_q, stim_d, stim_rep;
  logic [31:0]         misr_q, misr_d, resp_fold, lfsr_state;
  logic [CNT_W-1:0]    vec_cnt_q, vec_cnt_d, num_vec_q, num_vec_d, cnt_inc;
  logic [7:0]          wait_q, wait_d;
  logic [FOLD_MAX_W-1:0] resp_pad;

  fuzz_lfsr32 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (state_q == LOAD),
    .en_i    (state_q == APPLY),
    .seed_i  (seed_i),
    .state_o (lfsr_state)
  );

  always_comb begin
    resp_pad = '0;
    resp_pad[RESP_W-1:0] = resp_i;
    resp_fold = fold32(resp_pad, OUT_W);
  end

  // Wide stimulus ports repeat the 32-bit LFSR word from the LSB upward.
  always_comb begin
    stim_rep = '0;
    if (IN_W != 0) begin
      for (int unsigned i = 0; i < STIM_W; i++) stim_rep[i] = lfsr_state[i % 32];
    end
  end

  always_comb begin
    state_d   = state_q;
    stim_d    = stim_q;
    misr_d    = misr_q;
    vec_cnt_d = vec_cnt_q;
    num_vec_d = num_vec_q;
    wait_d    = wait_q;
    cnt_inc   = vec_cnt_q + 1'b1;
    case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD: begin
        misr_d    = '0;
        vec_cnt_d = '0;
        num_vec_d = num_vec_i;
        state_d   = (num_vec_i == '0) ? DONE : APPLY;
      end
      APPLY: begin
        stim_d  = stim_rep;
        wait_d  = '0;
        state_d = (SETTLE == 0) ? CAPTURE : WAIT;
      end
      WAIT: begin
        if (wait_q == SETTLE_LAST) state_d = CAPTURE;
        else                       wait_d  = wait_q + 8'd1;
      end
      CAPTURE: begin
        misr_d    = lfsr_step(misr_q) ^ resp_fold;
        vec_cnt_d = cnt_inc;
        state_d   = (cnt_inc == num_vec_q) ? DONE : APPLY;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef FUZZ_SEQ_ABORT_EN
    // Abort wins over a capture in the same cycle: that vector is not folded or counted.
    if (abort_i && (state_q inside {LOAD, APPLY, WAIT, CAPTURE})) begin
      state_d = DONE;
      if (state_q == CAPTURE) begin
        misr_d    = misr_q;
        vec_cnt_d = vec_cnt_q;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      stim_q    <= '0;
      misr_q    <= '0;
      vec_cnt_q <= '0;
      num_vec_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      stim_q    <= stim_d;
      misr_q    <= misr_d;
      vec_cnt_q <= vec_cnt_d;
      num_vec_q <= num_vec_d;
      wait_q    <= wait_d;
    end
  end

  assign stim_o      = stim_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign vec_cnt_o   = vec_cnt_q;
  assign signature_o = misr_q;

endmodule

// File: tb/tb_fuzz_wrapper_sequencer.sv
// Directed bench for fuzz_wrapper_sequencer (IN_W=40, OUT_W=48, SETTLE=2) with a
// stimulus/signature scoreboard and a response model driven from stim_o.
module tb_fuzz_wrapper_sequencer;

  localparam int unsigned IN_W   = 40;
  localparam int unsigned OUT_W  = 48;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned CNT_W  = 16;
  localparam int          P      = SETTLE + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              abort_i;
  logic              start_i;
  logic [31:0]       seed_i;
  logic [CNT_W-1:0]  num_vec_i;
  logic [IN_W-1:0]   stim_o;
  logic [OUT_W-1:0]  resp_i;
  logic              busy_o;
  logic              done_o;
  logic [CNT_W-1:0]  vec_cnt_o;
  logic [31:0]       signature_o;

  int resp_mode;
  int errors = 0;
  int checks = 0;

  logic [39:0] stim_sb[$];
  logic [31:0] sig_sb[$];
  int          cnt_sb[$];

  logic [39:0] first_stim, second_stim;
  logic [31:0] last_sig;

  always #5 clk = ~clk;

  fuzz_wrapper_sequencer #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .SETTLE (SETTLE),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef FUZZ_SEQ_ABORT_EN
    .abort_i     (abort_i),
`endif
    .start_i     (start_i),
    .seed_i      (seed_i),
    .num_vec_i   (num_vec_i),
    .stim_o      (stim_o),
    .resp_i      (resp_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .vec_cnt_o   (vec_cnt_o),
    .signature_o (signature_o)
  );

  function automatic logic [31:0] m_step(input logic [31:0] x);
    logic [31:0] y;
    y = {1'b0, x[31:1]};
    if (x[0]) y = y ^ 32'hA300_0000;
    return y;
  endfunction

  function automatic logic [39:0] m_rep(input logic [31:0] l);
    return {l[7:0], l};
  endfunction

  function automatic logic [31:0] m_fold(input logic [47:0] r);
    return r[31:0] ^ {16'h0, r[47:32]};
  endfunction

  function automatic logic [47:0] m_resp(input int mode, input logic [39:0] s);
    case (mode)
      0:       return 48'h0;
      1:       return 48'h1;
      default: return {s[15:0] ^ 16'h5A5A, s[39:8]};
    endcase
  endfunction

  always_comb resp_i = m_resp(resp_mode, stim_o);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; that cycle is cycle 0 (start_i sampled at its closing edge).
  task automatic run_vec(input logic [31:0] seed, input int n, input int mode);
    int          done_t, k;
    logic [31:0] l, m;
    logic [39:0] s;
    resp_mode = mode;
    done_t = 2 + n * P;
    l = (seed == 32'h0) ? 32'h1 : seed;
    m = 32'h0;
    for (int v = 0; v < n; v++) begin
      s = m_rep(l);
      stim_sb.push_back(s);
      m = m_step(m) ^ m_fold(m_resp(mode, s));
      l = m_step(l);
    end
    sig_sb.push_back(m);
    cnt_sb.push_back(n);
    seed_i    = seed;
    num_vec_i = CNT_W'(n);
    start_i   = 1'b1;
    k = 0;
    for (int t = 1; t <= done_t + 1; t++) begin
      @(negedge clk);
      start_i = 1'b0;
      check("busy", 64'(busy_o), 64'(t <= done_t));
      check("done", 64'(done_o), 64'(t == done_t));
      if (t >= 3 && (t - 3) % P == 0 && (t - 3) / P < n) begin
        s = stim_sb.pop_front();
        check("stim", 64'(stim_o), 64'(s));
        if (k == 0) first_stim = stim_o;
        if (k == 1) second_stim = stim_o;
        k++;
      end
      if (t == done_t) begin
        last_sig = signature_o;
        check("signature", 64'(signature_o), 64'(sig_sb.pop_front()));
        check("vec_cnt", 64'(vec_cnt_o), 64'(cnt_sb.pop_front()));
      end
      if (t == done_t + 1) check("sig_hold", 64'(signature_o), 64'(m));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    abort_i   = 1'b0;
    start_i   = 1'b1;
    seed_i    = 32'h0;
    num_vec_i = '0;
    resp_mode = 0;

    // Reset with start_i held high
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_done", 64'(done_o), 64'h0);
    check("rst_stim", 64'(stim_o), 64'h0);
    check("rst_cnt",  64'(vec_cnt_o), 64'h0);
    check("rst_sig",  64'(signature_o), 64'h0);
    rst_n   = 1'b1;
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_rst", 64'(busy_o), 64'h0);

    // Zero vectors
    run_vec(32'hDEAD_BEEF, 0, 2);
    check("zero_sig", 64'(last_sig), 64'h0);

    // Stimulus sequence from seed 1, constant response 1
    run_vec(32'h1, 2, 1);
    check("seed1_first_lo8",  64'(first_stim[7:0]), 64'h01);
    check("seed1_second_lo8", 64'(second_stim[7:0]), 64'h00);
    check("seed1_second", 64'(second_stim), 64'h00_A300_0000);
    check("const1_sig", 64'(last_sig), 64'hA300_0001);

    // Seed zero replaced by 1
    run_vec(32'h0, 1, 2);
    check("seed0_first", 64'(first_stim), 64'h01_0000_0001);

    // Timing with modelled response; zero response compaction
    run_vec(32'h1234_5678, 3, 2);
    run_vec(32'hCAFE_0001, 5, 0);
    check("zero_resp_sig", 64'(last_sig), 64'h0);
    run_vec(32'h8000_0003, 6, 2);

    // Reset mid-run during WAIT of vector 2
    resp_mode = 2;
    seed_i    = 32'h5555_AAAA;
    num_vec_i = 16'd3;
    start_i   = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_cnt", 64'(vec_cnt_o), 64'h1);
    check("pre_rst_busy", 64'(busy_o), 64'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy_o), 64'h0);
    check("mid_rst_cnt",  64'(vec_cnt_o), 64'h0);
    check("mid_rst_sig",  64'(signature_o), 64'h0);
    check("mid_rst_stim", 64'(stim_o), 64'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mid_rst_done", 64'(done_o), 64'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_done", 64'(done_o), 64'h0);
      check("post_rst_busy", 64'(busy_o), 64'h0);
    end

`ifdef FUZZ_SEQ_ABORT_EN
    begin
      logic [31:0] l0;
      resp_mode = 2;
      seed_i    = 32'h0BAD_F00D;
      num_vec_i = 16'd4;
      start_i   = 1'b1;
      l0 = 32'h0BAD_F00D;
      @(negedge clk);
      start_i = 1'b0;
      repeat (6) @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      check("abort_done", 64'(done_o), 64'h1);
      check("abort_cnt",  64'(vec_cnt_o), 64'h1);
      check("abort_sig",  64'(signature_o), 64'(m_fold(m_resp(2, m_rep(l0)))));
      @(negedge clk);
      check("abort_idle", 64'(busy_o), 64'h0);
    end
`endif

    check("sb_empty", 64'(stim_sb.size() + sig_sb.size() + cnt_sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fuzz_wrapper_sequencer.md
# fuzz_wrapper_sequencer

Stimulus sequencer and response compactor for flattened fuzz wrappers. It drives a wrapper's `in_flat` with a seeded pseudo-random vector stream, waits a fixed settle time per vector, and folds each sampled `out_flat` into a 32-bit MISR signature. It sits between the run harness and one `*_wrapper` instance, so every generated module is exercised by the same controller regardless of port widths, including zero-width ones.

## Interface

- `IN_W`, 32, width of wrapper `in_flat`; 0 allowed (stimulus port is then 1 bit, tied 0).
- `OUT_W`, 32, width of wrapper `out_flat`; 0 allowed (response port is then 1 bit, ignored).
- `SETTLE`, 2, cycles waited between apply and capture; range 0..255.
- `CNT_W`, 16, width of the vector counter.
- `clk`, input, 1, clock; all logic on rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `start_i`, input, 1, begin a run; sampled only in IDLE.
- `seed_i`, input, 32, LFSR seed, latched in LOAD; 0 is replaced by 1.
- `num_vec_i`, input, CNT_W, vectors per run, latched in LOAD.
- `stim_o`, output, max(IN_W,1), registered stimulus to `in_flat`.
- `resp_i`, input, max(OUT_W,1), wrapper `out_flat`.
- `busy_o`, output, 1, high whenever state is not IDLE.
- `done_o`, output, 1, one-cycle pulse in DONE.
- `vec_cnt_o`, output, CNT_W, vectors captured so far.
- `signature_o`, output, 32, MISR value; held from DONE until the next LOAD.

## Operation

- States: IDLE, LOAD, APPLY, WAIT, CAPTURE, DONE.
- IDLE -> LOAD on `start_i`. `start_i` is ignored in every other state.
- LOAD: `lfsr <= seed` (or 1 if seed is 0), `misr <= 0`, `vec_cnt <= 0`, latch `num_vec`. Next state is DONE if `num_vec == 0`, otherwise APPLY.
- APPLY: `stim_o <= lfsr` replicated and truncated to IN_W, LSB-aligned; advance the LFSR. Next state is WAIT if SETTLE > 0, else CAPTURE.
- LFSR step: `next = (x >> 1) ^ (x[0] ? 32'hA300_0000 : 0)`.
- WAIT: count SETTLE cycles, then go to CAPTURE. `stim_o` is held stable.
- CAPTURE:
  - `misr <= step(misr) ^ fold(resp_i)`, using the same step function as the LFSR.
  - `fold` is the XOR of 32-bit chunks of `resp_i`, zero-padded. When OUT_W = 0, fold is 0.
  - `vec_cnt++`. Go to DONE when the new count equals `num_vec`, else APPLY.
- DONE: `done_o = 1` for one cycle, then IDLE. `signature_o` and `vec_cnt_o` are retained; `stim_o` keeps its last value.
- Counter arithmetic is unsigned, with no wrap; `num_vec` ≤ 2^CNT_W − 1.

## Timing

- Reset values: state IDLE, `stim_o` 0, `busy_o` 0, `done_o` 0, `vec_cnt_o` 0, `signature_o` 0, LFSR 1.
- Reset asserted mid-run returns immediately to IDLE with all reset values; no `done_o` is produced.
- Per-vector period is SETTLE + 2 cycles.
- If `start_i` is sampled in cycle 0, `done_o` is high in cycle 2 + num_vec·(SETTLE+2).
- `resp_i` is sampled only in CAPTURE, which gives SETTLE+1 cycles after `stim_o` changes.

## Configuration

- `FUZZ_SEQ_ABORT_EN` defined: adds input `abort_i`.
  - `abort_i` high in LOAD, APPLY, WAIT or CAPTURE forces DONE on the next cycle, skipping any pending capture.
  - The signature is the partial MISR; `done_o` pulses normally.
  - `abort_i` has priority over a simultaneous capture transition.
- Not defined: no `abort_i` port; every run completes all vectors.

## Structure

- Package `fuzz_seq_pkg` holds:
  - the state enum `seq_state_e`;
  - `LFSR_TAPS = 32'hA300_0000`;
  - `function fold32` (parameterized by width);
  - `function lfsr_step`.
- One sub-module, `fuzz_lfsr32`: a loadable, enable-gated 32-bit Galois LFSR, used for stimulus generation. The MISR reuses `lfsr_step` from the package inline.

## Test plan

- Reset: hold `rst_n` low, then release → all outputs 0 and state IDLE; `start_i` during reset has no effect.
- Zero vectors: `num_vec=0`, start at cycle 0 → `done_o` in cycle 2, `signature_o=0`, `vec_cnt_o=0`.
- Stimulus sequence: IN_W=8, seed=1 → first `stim_o=8'h01`, second `stim_o=8'h00` (LFSR=`32'hA300_0000`).
- Seed zero: IN_W=32, seed=0 → first `stim_o=32'h1`.
- Timing: SETTLE=2, `num_vec=3`, start at cycle 0 → `done_o` only in cycle 14, `busy_o` high in cycles 1–14.
- Compaction:
  - `resp_i=0`, `num_vec=5` → signature 0.
  - `resp_i=32'h1` constant, `num_vec=2` → signature `32'hA300_0001`.
- Reset mid-run: assert `rst_n` low in WAIT → returns to IDLE, `vec_cnt_o=0`, no `done_o`. Compile with `FUZZ_SEQ_ABORT_EN`, raise `abort_i` during vector 2 of 4 → `done_o` next cycle, `vec_cnt_o=1`.
